adc_scan_avg: RTL and testbench

Downstream consumer of the LTC2308 serial ADC interface. It drives the interface's 3-bit channel select round-robin and captures each 12-bit conversion result on a one-cycle strobe. It tags each result with the channel that produced it, accounting for the converter's one-frame config pipeline, and averages 2^AVG_LOG2 samples per channel. Per-channel averages go to a readable register bank and to a streaming valid pulse for the display/control logic.

---
 rtl/adc_scan_avg.sv | 199 +++++++++++++++++++
 tb/tb_adc_scan_avg.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_scan_avg.sv
// adc_scan_avg: round-robin LTC2308 channel scan with per-channel
// averaging, a read-back bank and a streaming average pulse.
//
// Ports:
//   clk, reset_n          clock, async active-low reset
//   en                    scan enable (level)
//   result, result_stb    conversion result and its 1-cycle strobe
//   chan                  channel select driven to the ADC interface
//   avg_data/ch/valid     latest completed average, its channel, pulse
//   rd_ch, rd_data        bank read-back, registered, 1-cycle latency
// Optional (macro ADC_SCAN_THRESH_EN):
//   thresh, alarm_clr     alarm threshold and clear
//   alarm                 sticky per-channel over-threshold flags

module adc_scan_avg #(
  parameter int NUM_CH     = 8,
  parameter int AVG_LOG2   = 2,
  parameter int PIPE_DEPTH = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        en,
  input  logic [11:0] result,
  input  logic        result_stb,
  output logic [2:0]  chan,
  output logic [11:0] avg_data,
  output logic [2:0]  avg_ch,
  output logic        avg_valid,
  input  logic [2:0]  rd_ch,
  output logic [11:0] rd_data
`ifdef ADC_SCAN_THRESH_EN
  ,
  input  logic [11:0] thresh,
  input  logic        alarm_clr,
  output logic [7:0]  alarm
`endif
);

  localparam int AW = 12 + AVG_LOG2;
  localparam int CW = AVG_LOG2 + 1;
  localparam logic [CW-1:0] CNT_FULL =
    CW'(1) << AVG_LOG2;
  localparam logic [2:0] LAST_CH = 3'(NUM_CH - 1);

  logic          r_en_d;
  logic [2:0]    r_chan;
  logic [11:0]   r_avg_data;
  logic [2:0]    r_avg_ch;
  logic          r_avg_valid;
  logic [11:0]   r_rd_data;

  logic [PIPE_DEPTH-1:0] r_tag_v;
  logic [2:0]    r_tag_ch [PIPE_DEPTH];

  // Sized to the full 3-bit channel space so any
  // channel code indexes in range; unused entries
  // never leave reset.
  logic [AW-1:0] r_acc  [8];
  logic [CW-1:0] r_cnt  [8];
  logic [11:0]   r_bank [8];

  logic          w_en_rise;
  logic          w_acc_stb;
  logic          w_head_v;
  logic [2:0]    w_head_ch;
  logic [AW-1:0] w_sum;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_upd;
  logic          w_done;
  logic [11:0]   w_avg;

  assign w_en_rise = en & ~r_en_d;
  assign w_acc_stb = en & result_stb;

  // A strobe in the enable-edge cycle is treated
  // as arriving against an invalidated head.
  assign w_head_v  = r_tag_v[0] & ~w_en_rise;
  assign w_head_ch = r_tag_ch[0];

  assign w_sum     = r_acc[w_head_ch] + AW'(result);
  assign w_cnt_nxt = r_cnt[w_head_ch] + CW'(1);
  assign w_upd     = w_acc_stb & w_head_v;
  assign w_done    = w_upd & (w_cnt_nxt == CNT_FULL);
  assign w_avg     = 12'(w_sum >> AVG_LOG2);

  assign chan      = r_chan;
  assign avg_data  = r_avg_data;
  assign avg_ch    = r_avg_ch;
  assign avg_valid = r_avg_valid;
  assign rd_data   = r_rd_data;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_en_d <= 1'b0;
    end else begin
      r_en_d <= en;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_chan <= '0;
    end else if (w_acc_stb) begin
      r_chan <= (r_chan == LAST_CH) ?
                3'd0 : r_chan + 3'd1;
    end
  end

  // Tag pipeline models the converter's config
  // latency: the tail takes the channel driven now,
  // the head names the result arriving now.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tag_v <= '0;
      for (int i = 0; i < PIPE_DEPTH; i++)
        r_tag_ch[i] <= '0;
    end else if (w_acc_stb) begin
      for (int i = 0; i < PIPE_DEPTH - 1; i++) begin
        r_tag_v[i]  <= r_tag_v[i+1] & ~w_en_rise;
        r_tag_ch[i] <= r_tag_ch[i+1];
      end
      r_tag_v[PIPE_DEPTH-1]  <= 1'b1;
      r_tag_ch[PIPE_DEPTH-1] <= r_chan;
    end else if (w_en_rise) begin
      r_tag_v <= '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 8; i++) begin
        r_acc[i] <= '0;
        r_cnt[i] <= '0;
      end
    end else if (w_en_rise) begin
      for (int i = 0; i < 8; i++) begin
        r_acc[i] <= '0;
        r_cnt[i] <= '0;
      end
    end else if (w_upd) begin
      if (w_done) begin
        r_acc[w_head_ch] <= '0;
        r_cnt[w_head_ch] <= '0;
      end else begin
        r_acc[w_head_ch] <= w_sum;
        r_cnt[w_head_ch] <= w_cnt_nxt;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_avg_data  <= '0;
      r_avg_ch    <= '0;
      r_avg_valid <= 1'b0;
      for (int i = 0; i < 8; i++)
        r_bank[i] <= '0;
    end else begin
      r_avg_valid <= w_done;
      if (w_done) begin
        r_avg_data       <= w_avg;
        r_avg_ch         <= w_head_ch;
        r_bank[w_head_ch] <= w_avg;
      end
    end
  end

  // Reads sample the bank before this cycle's write,
  // so a same-channel write shows up one cycle later.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_data <= '0;
    end else begin
      r_rd_data <= (rd_ch <= LAST_CH) ?
                   r_bank[rd_ch] : 12'h000;
    end
  end

`ifdef ADC_SCAN_THRESH_EN
  logic [7:0] r_alarm;
  logic [7:0] w_alarm_set;

  assign w_alarm_set =
    (w_done && (w_avg > thresh)) ?
    (8'h01 << w_head_ch) : 8'h00;
  assign alarm = r_alarm;

  // Set is OR-ed after the clear so it wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_alarm <= '0;
    end else begin
      r_alarm <= (alarm_clr ? 8'h00 : r_alarm) |
                 w_alarm_set;
    end
  end
`endif

endmodule

// File: tb/tb_adc_scan_avg.sv
// tb_adc_scan_avg: directed self-checking bench for adc_scan_avg.
// Three instances share stimulus: a (AVG 0), b (AVG 2), c (2 ch).

module tb_adc_scan_avg;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        en;
  logic [11:0] result;
  logic        result_stb;
  logic [2:0]  rd_ch;

  logic [2:0]  a_chan, b_chan, c_chan;
  logic [11:0] a_avg_data, b_avg_data, c_avg_data;
  logic [2:0]  a_avg_ch, b_avg_ch, c_avg_ch;
  logic        a_avg_valid, b_avg_valid, c_avg_valid;
  logic [11:0] a_rd_data, b_rd_data, c_rd_data;

`ifdef ADC_SCAN_THRESH_EN
  logic [11:0] thresh;
  logic        alarm_clr;
  logic [7:0]  a_alarm, b_alarm, c_alarm;
`endif

  int errors = 0;
  int checks = 0;
  int s_b;
  int c0_b;

  always #5 clk = ~clk;

  adc_scan_avg #(.NUM_CH(8), .AVG_LOG2(0),
                 .PIPE_DEPTH(1)) u_a (
    .clk(clk), .reset_n(reset_n), .en(en),
    .result(result), .result_stb(result_stb),
    .chan(a_chan), .avg_data(a_avg_data),
    .avg_ch(a_avg_ch), .avg_valid(a_avg_valid),
    .rd_ch(rd_ch), .rd_data(a_rd_data)
`ifdef ADC_SCAN_THRESH_EN
    , .thresh(thresh), .alarm_clr(alarm_clr),
    .alarm(a_alarm)
`endif
  );

  adc_scan_avg #(.NUM_CH(8), .AVG_LOG2(2),
                 .PIPE_DEPTH(1)) u_b (
    .clk(clk), .reset_n(reset_n), .en(en),
    .result(result), .result_stb(result_stb),
    .chan(b_chan), .avg_data(b_avg_data),
    .avg_ch(b_avg_ch), .avg_valid(b_avg_valid),
    .rd_ch(rd_ch), .rd_data(b_rd_data)
`ifdef ADC_SCAN_THRESH_EN
    , .thresh(thresh), .alarm_clr(alarm_clr),
    .alarm(b_alarm)
`endif
  );

  adc_scan_avg #(.NUM_CH(2), .AVG_LOG2(0),
                 .PIPE_DEPTH(1)) u_c (
    .clk(clk), .reset_n(reset_n), .en(en),
    .result(result), .result_stb(result_stb),
    .chan(c_chan), .avg_data(c_avg_data),
    .avg_ch(c_avg_ch), .avg_valid(c_avg_valid),
    .rd_ch(rd_ch), .rd_data(c_rd_data)
`ifdef ADC_SCAN_THRESH_EN
    , .thresh(thresh), .alarm_clr(alarm_clr),
    .alarm(c_alarm)
`endif
  );

  task automatic do_reset();
    @(negedge clk);
    reset_n    = 1'b0;
    en         = 1'b0;
    result     = 12'h000;
    result_stb = 1'b0;
    rd_ch      = 3'd0;
`ifdef ADC_SCAN_THRESH_EN
    thresh    = 12'h800;
    alarm_clr = 1'b0;
`endif
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic enable();
    en = 1'b1;
    @(negedge clk);
  endtask

  task automatic pulse(input logic [11:0] v);
    @(negedge clk);
    result     = v;
    result_stb = 1'b1;
    @(negedge clk);
    result_stb = 1'b0;
  endtask

  task automatic run_b(
    input logic [11:0] v0, v1, v2, v3,
    input int n, input int exp_hits,
    input logic [11:0] exp_avg, exp_old
  );
    logic [11:0] vals [4];
    logic [11:0] v;
    int j;
    int hits;
    int tag;
    vals[0] = v0; vals[1] = v1;
    vals[2] = v2; vals[3] = v3;
    j = 0;
    hits = 0;
    for (int i = 0; i < n; i++) begin
      tag = (c0_b + s_b + 7) % 8;
      v = 12'h000;
      if (s_b == 0) v = 12'hFFF;
      else if (tag == 3 && j < 4) begin
        v = vals[j];
        j++;
      end
      pulse(v);
      s_b++;
      if (b_avg_valid === 1'b1) begin
        if (b_avg_ch === 3'd3) begin
          hits++;
          checks++;
          if (b_avg_data !== exp_avg) begin
            errors++;
            $display("FAIL b_avg3 got=%h exp=%h",
                     b_avg_data, exp_avg);
          end
          checks++;
          if (b_rd_data !== exp_old) begin
            errors++;
            $display("FAIL b_rd_old got=%h exp=%h",
                     b_rd_data, exp_old);
          end
          @(negedge clk);
          checks++;
          if (b_rd_data !== exp_avg) begin
            errors++;
            $display("FAIL b_rd_new got=%h exp=%h",
                     b_rd_data, exp_avg);
          end
        end else begin
          checks++;
          if (b_avg_data !== 12'h000) begin
            errors++;
            $display("FAIL b_other ch=%0d got=%h exp=0",
                     b_avg_ch, b_avg_data);
          end
        end
      end
    end
    checks++;
    if (hits !== exp_hits) begin
      errors++;
      $display("FAIL b_hits got=%0d exp=%0d",
               hits, exp_hits);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({a_chan, a_avg_data, a_avg_ch,
         a_avg_valid, a_rd_data} !== 31'd0) begin
      errors++;
      $display("FAIL reset_a got=%h %h %h %b %h exp=0",
               a_chan, a_avg_data, a_avg_ch,
               a_avg_valid, a_rd_data);
    end
    checks++;
    if ({b_chan, b_avg_data, b_avg_ch,
         b_avg_valid, b_rd_data} !== 31'd0) begin
      errors++;
      $display("FAIL reset_b got=%h %h %h %b %h exp=0",
               b_chan, b_avg_data, b_avg_ch,
               b_avg_valid, b_rd_data);
    end
    checks++;
    if ({c_chan, c_avg_data, c_avg_ch,
         c_avg_valid, c_rd_data} !== 31'd0) begin
      errors++;
      $display("FAIL reset_c got=%h %h %h %b %h exp=0",
               c_chan, c_avg_data, c_avg_ch,
               c_avg_valid, c_rd_data);
    end
`ifdef ADC_SCAN_THRESH_EN
    checks++;
    if (a_alarm !== 8'h00) begin
      errors++;
      $display("FAIL reset_alarm got=%h exp=00",
               a_alarm);
    end
`endif
  endtask

  task automatic test_passthru();
    do_reset();
    enable();
    for (int k = 0; k < 10; k++) begin
      checks++;
      if (a_chan !== 3'(k % 8)) begin
        errors++;
        $display("FAIL pt_chan k=%0d got=%0d exp=%0d",
                 k, a_chan, k % 8);
      end
      pulse(12'h100 + 12'(k));
      if (k == 0) begin
        checks++;
        if (a_avg_valid !== 1'b0) begin
          errors++;
          $display("FAIL pt_discard got=%b exp=0",
                   a_avg_valid);
        end
      end else begin
        checks++;
        if ({a_avg_valid, a_avg_ch, a_avg_data} !==
            {1'b1, 3'((k - 1) % 8),
             12'h100 + 12'(k)}) begin
          errors++;
          $display("FAIL pt_out k=%0d got=%b/%0d/%h exp=1/%0d/%h",
                   k, a_avg_valid, a_avg_ch, a_avg_data,
                   (k - 1) % 8, 12'h100 + 12'(k));
        end
      end
    end
  endtask

  task automatic test_avg4();
    do_reset();
    rd_ch = 3'd3;
    enable();
    c0_b = 0;
    s_b  = 0;
    run_b(12'd10, 12'd11, 12'd12, 12'd14,
          32, 1, 12'd11, 12'd0);
  endtask

  task automatic test_max();
    run_b(12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF,
          32, 1, 12'hFFF, 12'd11);
  endtask

  task automatic test_en_toggle();
    do_reset();
    rd_ch = 3'd3;
    enable();
    c0_b = 0;
    s_b  = 0;
    run_b(12'd100, 12'd100, 12'd0, 12'd0,
          13, 0, 12'd0, 12'd0);
    checks++;
    if (b_chan !== 3'd5) begin
      errors++;
      $display("FAIL en_pre_chan got=%0d exp=5", b_chan);
    end
    en = 1'b0;
    repeat (3) begin
      pulse(12'h7FF);
      checks++;
      if ({b_chan, b_avg_valid} !== {3'd5, 1'b0}) begin
        errors++;
        $display("FAIL en_low got=%0d/%b exp=5/0",
                 b_chan, b_avg_valid);
      end
    end
    enable();
    checks++;
    if (b_chan !== 3'd5) begin
      errors++;
      $display("FAIL en_rise_chan got=%0d exp=5", b_chan);
    end
    c0_b = 5;
    s_b  = 0;
    run_b(12'd200, 12'd200, 12'd200, 12'd200,
          40, 1, 12'd200, 12'd0);
  endtask

  task automatic test_back_to_back();
    do_reset();
    enable();
    result     = 12'h010;
    result_stb = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (i == 1) begin
        checks++;
        if (c_avg_valid !== 1'b0) begin
          errors++;
          $display("FAIL b2b_discard got=%b exp=0",
                   c_avg_valid);
        end
      end else begin
        checks++;
        if ({c_avg_valid, c_avg_ch, c_avg_data} !==
            {1'b1, 3'((i - 2) % 2),
             12'h010 + 12'(i - 1)}) begin
          errors++;
          $display("FAIL b2b_out i=%0d got=%b/%0d/%h exp=1/%0d/%h",
                   i, c_avg_valid, c_avg_ch, c_avg_data,
                   (i - 2) % 2, 12'h010 + 12'(i - 1));
        end
      end
      checks++;
      if (c_chan !== 3'(i % 2)) begin
        errors++;
        $display("FAIL b2b_chan i=%0d got=%0d exp=%0d",
                 i, c_chan, i % 2);
      end
      if (i < 6) result = 12'h010 + 12'(i);
      else result_stb = 1'b0;
    end
    rd_ch = 3'd1;
    @(negedge clk);
    checks++;
    if (c_rd_data !== 12'h014) begin
      errors++;
      $display("FAIL b2b_rd1 got=%h exp=014", c_rd_data);
    end
    rd_ch = 3'd5;
    @(negedge clk);
    checks++;
    if (c_rd_data !== 12'h000) begin
      errors++;
      $display("FAIL rd_oob got=%h exp=000", c_rd_data);
    end
  endtask

`ifdef ADC_SCAN_THRESH_EN
  task automatic test_thresh();
    logic [11:0] v;
    do_reset();
    thresh = 12'h800;
    enable();
    for (int s = 0; s <= 22; s++) begin
      v = 12'h000;
      if (s == 6)  v = 12'h800;
      if (s == 14) v = 12'h801;
      if (s == 22) v = 12'h900;
      @(negedge clk);
      result     = v;
      result_stb = 1'b1;
      alarm_clr  = (s == 22);
      @(negedge clk);
      result_stb = 1'b0;
      alarm_clr  = 1'b0;
      if (s == 6) begin
        checks++;
        if (a_alarm !== 8'h00) begin
          errors++;
          $display("FAIL th_equal got=%h exp=00", a_alarm);
        end
      end
      if (s == 14) begin
        checks++;
        if (a_alarm !== 8'h20) begin
          errors++;
          $display("FAIL th_set got=%h exp=20", a_alarm);
        end
        @(negedge clk);
        alarm_clr = 1'b1;
        @(negedge clk);
        alarm_clr = 1'b0;
        checks++;
        if (a_alarm !== 8'h00) begin
          errors++;
          $display("FAIL th_clr got=%h exp=00", a_alarm);
        end
      end
      if (s == 22) begin
        checks++;
        if (a_alarm !== 8'h20) begin
          errors++;
          $display("FAIL th_setwins got=%h exp=20",
                   a_alarm);
        end
      end
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_passthru();
    test_avg4();
    test_max();
    test_en_toggle();
    test_back_to_back();
`ifdef ADC_SCAN_THRESH_EN
    test_thresh();
`endif
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
